// File: rtl/ctrl_pad_sequencer.sv
// ctrl_pad_sequencer
// Drives the valve control / flush pad ring of a microfluidic bank and a set
// of independent peristaltic pumps.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   cmd_valid/ready : valve command handshake (cmd_chan, cmd_open)
//   pump_en/dir/div : per-pump enable and direction, shared step divider
//   pad_ctrl        : valve pressure drive, 1 = closed
//   pad_flush       : flush pad drive, 1 = flushing (at most one bit high)
//   pad_pump        : pump valve drive, pump p at [p*PUMP_PHASES +: PUMP_PHASES]
//   busy            : command FSM not idle
//   err_bad_chan    : sticky, an out-of-range channel was commanded
//   stroke_cnt      : per-pump 16-bit stroke counters
//
// Optional feature macro: PUMP_STROKE_CNT_EN
//   defined   -> stroke_cnt counts index wraps of each pump
//   undefined -> stroke_cnt is tied to zero
module ctrl_pad_sequencer #(
  parameter int N_CTRL       = 13,
  parameter int N_PUMP       = 2,
  parameter int PUMP_PHASES  = 3,
  parameter int DIV_W        = 16,
  parameter int FLUSH_CYCLES = 8,
  localparam int CHAN_W      = (N_CTRL > 1) ? $clog2(N_CTRL) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [CHAN_W-1:0]             cmd_chan,
  input  logic                          cmd_open,
  input  logic [N_PUMP-1:0]             pump_en,
  input  logic [N_PUMP-1:0]             pump_dir,
  input  logic [DIV_W-1:0]              pump_div,
  output logic [N_CTRL-1:0]             pad_ctrl,
  output logic [N_CTRL-1:0]             pad_flush,
  output logic [N_PUMP*PUMP_PHASES-1:0] pad_pump,
  output logic                          busy,
  output logic                          err_bad_chan,
  output logic [N_PUMP*16-1:0]          stroke_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int PH_W = $clog2(PUMP_PHASES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // One-hot-low drive pattern: the active phase is open, every other valve closed.
  function automatic logic [PUMP_PHASES-1:0] phase_pattern(input logic [PH_W-1:0] s);
    logic [PUMP_PHASES-1:0] v;
    v    = {PUMP_PHASES{1'b1}};
    v[s] = 1'b0;
    return v;
  endfunction

  state_e            state_q;
  logic [CHAN_W-1:0] chan_q;
  logic              open_q;
  logic [FC_W-1:0]   flush_cnt_q;
  logic [N_CTRL-1:0] pad_ctrl_q;
  logic [N_CTRL-1:0] pad_flush_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              err_q;
  logic              bad_chan_s;

  assign bad_chan_s   = (32'(cmd_chan) >= 32'(N_CTRL));
  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign err_bad_chan = err_q;
  assign pad_ctrl     = pad_ctrl_q;
  assign pad_flush    = pad_flush_q;

  // Command FSM: accept, apply the valve change, then flush after an open->close.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
      open_q      <= 1'b0;
      flush_cnt_q <= '0;
      pad_ctrl_q  <= {N_CTRL{1'b1}};
      pad_flush_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            if (bad_chan_s) begin
              err_q <= 1'b1;
            end else begin
              chan_q      <= cmd_chan;
              open_q      <= cmd_open;
              state_q     <= S_APPLY;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        S_APPLY: begin
          pad_ctrl_q[chan_q] <= ~open_q;
          // Only a real open->closed transition leaves fluid to flush.
          if (!open_q && !pad_ctrl_q[chan_q]) begin
            state_q             <= S_FLUSH;
            pad_flush_q[chan_q] <= 1'b1;
            flush_cnt_q         <= FC_W'(FLUSH_CYCLES - 1);
          end else begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            pad_flush_q <= '0;
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: begin
          pad_flush_q <= '0;
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar p = 0; p < N_PUMP; p++) begin : g_pump
    logic [DIV_W-1:0]       div_cnt_q;
    logic [DIV_W-1:0]       term_q;
    logic [DIV_W-1:0]       term_live_s;
    logic [DIV_W-1:0]       term_eff_s;
    logic [PH_W-1:0]        step_q;
    logic [PH_W-1:0]        step_next_s;
    logic [PUMP_PHASES-1:0] pat_q;
    logic                   wrap_s;

    // Divider terminal count is sampled at the start of each period so a new
    // pump_div only takes effect after the current period wraps.
    always_comb begin
      term_live_s = (pump_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : pump_div - 1'b1;
      term_eff_s  = (div_cnt_q == {DIV_W{1'b0}}) ? term_live_s : term_q;
      wrap_s      = (div_cnt_q == term_eff_s);
      if (pump_dir[p]) begin
        step_next_s = (step_q == {PH_W{1'b0}}) ? PH_W'(PUMP_PHASES - 1) : step_q - 1'b1;
      end else begin
        step_next_s = (step_q == PH_W'(PUMP_PHASES - 1)) ? {PH_W{1'b0}} : step_q + 1'b1;
      end
    end

    // Pump stepper; the pattern shows the index held before the step so the
    // first phase is visible for a full divider period after enable.
    always_ff @(posedge clk) begin
      if (rst || !pump_en[p]) begin
        div_cnt_q <= '0;
        term_q    <= '0;
        step_q    <= '0;
        pat_q     <= {PUMP_PHASES{1'b1}};
      end else begin
        pat_q  <= phase_pattern(step_q);
        term_q <= term_eff_s;
        if (wrap_s) begin
          div_cnt_q <= '0;
          step_q    <= step_next_s;
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
      end
    end

    assign pad_pump[p*PUMP_PHASES +: PUMP_PHASES] = pat_q;

`ifdef PUMP_STROKE_CNT_EN
    logic [15:0] stroke_q;
    logic        idx_wrap_s;

    // A stroke completes when the index crosses between the last and first phase.
    always_comb begin
      if (pump_dir[p]) begin
        idx_wrap_s = (step_q == {PH_W{1'b0}});
      end else begin
        idx_wrap_s = (step_q == PH_W'(PUMP_PHASES - 1));
      end
    end

    // Stroke counter, holds while the pump is disabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        stroke_q <= 16'd0;
      end else if (pump_en[p] && wrap_s && idx_wrap_s) begin
        stroke_q <= stroke_q + 16'd1;
      end
    end

    assign stroke_cnt[p*16 +: 16] = stroke_q;
`else
    assign stroke_cnt[p*16 +: 16] = 16'd0;
`endif
  end

endmodule

// File: tb/tb_ctrl_pad_sequencer.sv
module tb_ctrl_pad_sequencer;

`ifdef PUMP_STROKE_CNT_EN
  localparam logic [15:0] EXP_STROKE = 16'd3;
`else
  localparam logic [15:0] EXP_STROKE = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_chan;
  logic        cmd_open;
  logic [1:0]  pump_en;
  logic [1:0]  pump_dir;
  logic [15:0] pump_div;
  logic [12:0] pad_ctrl;
  logic [12:0] pad_flush;
  logic [5:0]  pad_pump;
  logic        busy;
  logic        err_bad_chan;
  logic [31:0] stroke_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Expected pump-0 pattern, one entry per 4-clock step (dir flips before entry 5).
  logic [2:0] dir_seg [7] = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b110, 3'b011};
  logic [2:0] div0_seg [6] = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011};

  ctrl_pad_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_chan     (cmd_chan),
    .cmd_open     (cmd_open),
    .pump_en      (pump_en),
    .pump_dir     (pump_dir),
    .pump_div     (pump_div),
    .pad_ctrl     (pad_ctrl),
    .pad_flush    (pad_flush),
    .pad_pump     (pad_pump),
    .busy         (busy),
    .err_bad_chan (err_bad_chan),
    .stroke_cnt   (stroke_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++; if (pad_ctrl !== 13'h1FFF) $display("FAIL rst_pad_ctrl got %h exp %h", pad_ctrl, 13'h1FFF); else pass_cnt++;
      chk_cnt++; if (pad_pump !== 6'h3F) $display("FAIL rst_pad_pump got %h exp %h", pad_pump, 6'h3F); else pass_cnt++;
      chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_ready_busy got %b%b exp 10", cmd_ready, busy); else pass_cnt++;
    end
    chk_cnt++; if (pad_flush !== 13'h0 || err_bad_chan !== 1'b0) $display("FAIL rst_flush_err got %h/%b exp 0/0", pad_flush, err_bad_chan); else pass_cnt++;
    chk_cnt++; if (stroke_cnt !== 32'h0) $display("FAIL rst_stroke got %h exp 0", stroke_cnt); else pass_cnt++;
    rst = 1'b0;
    pump_en = 2'b00;
  endtask

  task automatic test_open_close();
    int low_n, flush_n, bad_n;
    cmd_valid = 1'b1; cmd_chan = 4'd5; cmd_open = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_cnt++; if (pad_ctrl !== 13'h1FFF) $display("FAIL open_apply_pad got %h exp %h", pad_ctrl, 13'h1FFF); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL open_apply_rb got %b%b exp 01", cmd_ready, busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pad_ctrl !== 13'h1FDF) $display("FAIL open_pad got %h exp %h", pad_ctrl, 13'h1FDF); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL open_done_rb got %b%b exp 10", cmd_ready, busy); else pass_cnt++;
    cmd_valid = 1'b1; cmd_open = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    low_n = 0; flush_n = 0; bad_n = 0;
    while (!cmd_ready && low_n < 30) begin
      low_n++;
      if (pad_flush === 13'h0020) flush_n++;
      else if (pad_flush !== 13'h0) bad_n++;
      @(negedge clk);
    end
    chk_cnt++; if (flush_n != 8) $display("FAIL flush_len got %0d exp 8", flush_n); else pass_cnt++;
    chk_cnt++; if (bad_n != 0) $display("FAIL flush_other_bits got %0d exp 0", bad_n); else pass_cnt++;
    chk_cnt++; if (low_n + 1 != 10) $display("FAIL close_accept_gap got %0d exp 10", low_n + 1); else pass_cnt++;
    chk_cnt++; if (pad_flush !== 13'h0 || pad_ctrl !== 13'h1FFF) $display("FAIL close_end got %h/%h exp 0/1fff", pad_flush, pad_ctrl); else pass_cnt++;
  endtask

  task automatic test_closed_and_bad();
    cmd_valid = 1'b1; cmd_chan = 4'd2; cmd_open = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reclose_ready_low got %b exp 0", cmd_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reclose_ready got %b%b exp 10", cmd_ready, busy); else pass_cnt++;
    chk_cnt++; if (pad_flush !== 13'h0) $display("FAIL reclose_flush got %h exp 0", pad_flush); else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++; if (pad_flush !== 13'h0 || pad_ctrl !== 13'h1FFF) $display("FAIL reclose_after got %h/%h exp 0/1fff", pad_flush, pad_ctrl); else pass_cnt++;
    cmd_valid = 1'b1; cmd_chan = 4'd13; cmd_open = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_cnt++; if (err_bad_chan !== 1'b1) $display("FAIL bad_chan_err got %b exp 1", err_bad_chan); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bad_chan_idle got %b%b exp 10", cmd_ready, busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (err_bad_chan !== 1'b1 || pad_ctrl !== 13'h1FFF) $display("FAIL bad_chan_sticky got %b/%h exp 1/1fff", err_bad_chan, pad_ctrl); else pass_cnt++;
    cmd_valid = 1'b1; cmd_chan = 4'd0; cmd_open = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pad_ctrl !== 13'h1FFE || err_bad_chan !== 1'b1) $display("FAIL open0_after_err got %h/%b exp 1ffe/1", pad_ctrl, err_bad_chan); else pass_cnt++;
  endtask

  task automatic test_pump_dir();
    pump_div = 16'd4; pump_dir = 2'b00; pump_en = 2'b01;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      chk_cnt++; if (pad_pump[2:0] !== dir_seg[k/4]) $display("FAIL pump_dir_seq[%0d] got %b exp %b", k, pad_pump[2:0], dir_seg[k/4]); else pass_cnt++;
      if (k == 16) pump_dir = 2'b01;
    end
    chk_cnt++; if (pad_pump[5:3] !== 3'b111) $display("FAIL pump1_idle got %b exp 111", pad_pump[5:3]); else pass_cnt++;
    pump_en = 2'b00; pump_dir = 2'b00;
    @(negedge clk);
    chk_cnt++; if (pad_pump !== 6'h3F) $display("FAIL pump0_off got %h exp 3f", pad_pump); else pass_cnt++;
  endtask

  task automatic test_pump_div0();
    pump_div = 16'd0; pump_en = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_cnt++; if (pad_pump[5:3] !== div0_seg[k]) $display("FAIL pump_div0_seq[%0d] got %b exp %b", k, pad_pump[5:3], div0_seg[k]); else pass_cnt++;
    end
    chk_cnt++; if (pad_pump[2:0] !== 3'b111) $display("FAIL pump0_stays_off got %b exp 111", pad_pump[2:0]); else pass_cnt++;
    pump_en = 2'b00;
    @(negedge clk);
    chk_cnt++; if (pad_pump[5:3] !== 3'b111) $display("FAIL pump1_drop got %b exp 111", pad_pump[5:3]); else pass_cnt++;
    pump_en = 2'b10;
    @(negedge clk);
    chk_cnt++; if (pad_pump[5:3] !== 3'b110) $display("FAIL pump1_reen0 got %b exp 110", pad_pump[5:3]); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pad_pump[5:3] !== 3'b101) $display("FAIL pump1_reen1 got %b exp 101", pad_pump[5:3]); else pass_cnt++;
    pump_en = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    cmd_valid = 1'b1; cmd_chan = 4'd0; cmd_open = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pad_flush !== 13'h0001) $display("FAIL midflush_active got %h exp 0001", pad_flush); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (pad_flush !== 13'h0) $display("FAIL midflush_abort got %h exp 0", pad_flush); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL midflush_idle got %b%b exp 01", busy, cmd_ready); else pass_cnt++;
    chk_cnt++; if (pad_ctrl !== 13'h1FFF || err_bad_chan !== 1'b0) $display("FAIL midflush_regs got %h/%b exp 1fff/0", pad_ctrl, err_bad_chan); else pass_cnt++;
    cmd_valid = 1'b1; cmd_chan = 4'd4; cmd_open = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    chk_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_vs_cmd_idle got %b%b exp 01", busy, cmd_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pad_ctrl !== 13'h1FFF) $display("FAIL rst_vs_cmd_drop got %h exp 1fff", pad_ctrl); else pass_cnt++;
  endtask

  task automatic test_stroke();
    pump_div = 16'd1; pump_dir = 2'b00; pump_en = 2'b01;
    repeat (9) @(negedge clk);
    pump_en = 2'b00;
    chk_cnt++; if (stroke_cnt[15:0] !== EXP_STROKE) $display("FAIL stroke0 got %0d exp %0d", stroke_cnt[15:0], EXP_STROKE); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (stroke_cnt[15:0] !== EXP_STROKE) $display("FAIL stroke0_hold got %0d exp %0d", stroke_cnt[15:0], EXP_STROKE); else pass_cnt++;
    chk_cnt++; if (stroke_cnt[31:16] !== 16'd0) $display("FAIL stroke1 got %0d exp 0", stroke_cnt[31:16]); else pass_cnt++;
    chk_cnt++; if (pad_pump !== 6'h3F) $display("FAIL stroke_pads_off got %h exp 3f", pad_pump); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_chan = 4'd0; cmd_open = 1'b0;
    pump_en = 2'b11; pump_dir = 2'b00; pump_div = 16'd0;
    test_reset();
    @(negedge clk);
    test_open_close();
    test_closed_and_bad();
    test_pump_dir();
    test_pump_div0();
    test_reset_mid_flush();
    test_stroke();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ctrl_pad_sequencer.md
Name: ctrl_pad_sequencer

Overview:
Parametrised sequential driver for the control and flush pad ring of a microfluidic bank.
- Valve channels: an N_CTRL-channel open/close command interface; every close is followed by a timed flush pulse on that channel's flush pad.
- Pumps: N_PUMP independent peristaltic pumps, each with a clock-divided, direction-selectable phase rotation.
- Placement: sits between the host control logic and the ctrl/flush pad holes of any bank wrapper. It replaces hand-wired, fixed-count pad drive.

Parameters:
N_CTRL, 13, number of valve control channels (1..64)
N_PUMP, 2, number of peristaltic pumps (1..8)
PUMP_PHASES, 3, valves per pump (3..6)
DIV_W, 16, width of pump step divider
FLUSH_CYCLES, 8, flush pulse length in clocks (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer can accept command
cmd_chan  input  $clog2(N_CTRL)  target valve channel
cmd_open  input  1  1=open valve, 0=close valve
pump_en  input  N_PUMP  per-pump run enable
pump_dir  input  N_PUMP  per-pump direction, 0=forward, 1=reverse
pump_div  input  DIV_W  clocks per pump step (shared by all pumps)
pad_ctrl  output  N_CTRL  valve pressure drive, 1=closed (pressurised)
pad_flush  output  N_CTRL  flush pad drive, 1=flushing
pad_pump  output  N_PUMP*PUMP_PHASES  pump valve drive, pump p occupies bits [p*PUMP_PHASES +: PUMP_PHASES], 1=closed
busy  output  1  FSM not in IDLE
err_bad_chan  output  1  sticky: command with cmd_chan >= N_CTRL was seen
stroke_cnt  output  N_PUMP*16  per-pump completed-stroke counters (see Optional Feature)

Behaviour:
- Reset values (all synchronous on rst=1):
  - pad_ctrl = all 1 (all valves closed); pad_flush = 0; pad_pump = all 1.
  - cmd_ready = 1; busy = 0; err_bad_chan = 0; stroke_cnt = 0.
  - FSM = IDLE; pump step indices = 0; pump dividers = 0.
- Reset mid-flush aborts the flush immediately.
- FSM states: IDLE, APPLY, FLUSH.
  - IDLE: cmd_ready=1. A handshake occurs when cmd_valid&cmd_ready.
    - cmd_chan >= N_CTRL: set err_bad_chan, stay IDLE, no pad change.
    - Otherwise latch the channel and open flag, go to APPLY.
  - APPLY (1 cycle): cmd_ready=0; pad_ctrl[chan] <= ~open, visible the cycle after APPLY.
    - Open command: return to IDLE.
    - Close command on a channel that was open: go to FLUSH.
    - Close command on an already-closed channel: return to IDLE, no flush.
  - FLUSH: pad_flush[chan]=1 for exactly FLUSH_CYCLES clocks; cmd_ready=0; then IDLE.
- Command latency: IDLE to pad_ctrl change = 2 clocks after the handshake edge. Next command accepted 2 clocks after the handshake (open), or 2+FLUSH_CYCLES clocks (close with flush).
- Only one pad_flush bit is ever high at a time.
- Pumps are independent of the FSM:
  - Per-pump divider counts 0..max(pump_div,1)-1. At terminal count it advances the step index s: forward s=(s+1) mod PUMP_PHASES; reverse s=(s-1) mod PUMP_PHASES. Both wrap.
  - Running pattern: phase s driven 0 (open), all others 1.
  - pump_div=0 behaves as 1 (a step every clock).
  - A pump_div change takes effect at the next divider wrap.
- pump_en falling: the next cycle that pump's pad_pump bits go all 1, and its step index and divider reset to 0.
- pump_en rising: first pattern (phase 0 open) appears the next cycle. The first step occurs after max(pump_div,1) clocks.
- pump_dir change while running applies at the next step; no glitch; the index is not reset.
- Simultaneous handshake and rst: rst wins, command dropped.

Optional Feature:
Macro PUMP_STROKE_CNT_EN.
- Defined: stroke_cnt[p] (16-bit, wraps 0xFFFF->0) increments each time pump p's index wraps (forward PUMP_PHASES-1->0, reverse 0->PUMP_PHASES-1). It holds while disabled and clears only on rst.
- Undefined: stroke_cnt tied to 0; no counter logic.

Test Plan:
- Reset with pump_en=2'b11, rst held 3 cycles -> pad_ctrl=13'h1FFF, pad_pump=6'h3F, cmd_ready=1, busy=0 throughout.
- Open chan 5 then close chan 5 (FLUSH_CYCLES=8) -> pad_ctrl[5]=0 2 clocks after first handshake; after close, pad_flush[5]=1 for exactly 8 clocks; cmd_ready low for 10 clocks after the second handshake.
- Close already-closed chan 2 -> no pad_flush activity; cmd_ready returns after 2 clocks; cmd_chan=13 -> err_bad_chan=1 sticky, pads unchanged.
- Pump 0, pump_div=4, dir=0 -> pad_pump[2:0] sequence 110,101,011,110 each held 4 clocks; set dir=1 mid-run -> reverses at next step without index reset.
- pump_div=0, pump 1 enabled -> pattern advances every clock; drop pump_en -> all phase bits 1 next cycle; re-enable -> phase 0 open again.
- With PUMP_STROKE_CNT_EN, pump_div=1, 9 clocks enabled, PUMP_PHASES=3 -> stroke_cnt[0]=3; assert rst mid-flush -> pad_flush=0 and FSM IDLE the next cycle.
